eth_rx_chan_filter: RTL and testbench
=====================================

Name: eth_rx_chan_filter

Overview:
- Multi-channel successor to the single-peer RX MAC filter.
- Takes a parsed Ethernet header plus its payload stream and matches the header against NUM_CH per-channel (local MAC, remote MAC, ethertype) entries.
- Steers matching frames to the owning channel's output and consumes non-matching frames whole, so they are dropped and never stall upstream.
- Sits between the eth_axis_rx header parser and the per-channel width adapters / user kernels.

Parameters:
- DATA_WIDTH, 512: payload tdata width in bits; multiple of 8. tkeep is DATA_WIDTH/8.
- NUM_CH, 4: number of filter channels / output ports; 1..16.
- CNT_WIDTH, 32: width of statistics counters.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  reset. Single clock; reset is asynchronous and active-high.
- s_eth_hdr_valid  in  1  parsed header valid.
- s_eth_hdr_ready  out  1  header accept.
- s_eth_dest_mac  in  48  received destination MAC.
- s_eth_src_mac  in  48  received source MAC.
- s_eth_type  in  16  received ethertype.
- s_eth_payload_axis_tdata  in  DATA_WIDTH  payload data.
- s_eth_payload_axis_tkeep  in  DATA_WIDTH/8  payload byte enables.
- s_eth_payload_axis_tvalid  in  1  payload valid.
- s_eth_payload_axis_tready  out  1  payload ready.
- s_eth_payload_axis_tlast  in  1  last payload beat.
- s_eth_payload_axis_tuser  in  1  frame error, meaningful on tlast.
- cfg_local_mac  in  NUM_CH*48  per-channel local MAC; channel k occupies [k*48 +: 48].
- cfg_remote_mac  in  NUM_CH*48  per-channel remote MAC.
- cfg_ethertype  in  NUM_CH*16  per-channel ethertype.
- cfg_ch_en  in  NUM_CH  per-channel enable.
- m_axis_net_rx_tvalid  out  NUM_CH  per-channel valid.
- m_axis_net_rx_tready  in  NUM_CH  per-channel ready.
- m_axis_net_rx_tdata  out  DATA_WIDTH  shared data bus, qualified per channel by tvalid.
- m_axis_net_rx_tkeep  out  DATA_WIDTH/8  shared.
- m_axis_net_rx_tlast  out  1  shared.
- m_axis_net_rx_tuser  out  1  shared; copies input tuser.

Behaviour:
- FSM states: IDLE, FWD, DROP. Reset state is IDLE.
- Reset values: all m_axis_net_rx_tvalid=0, s_eth_hdr_ready=0, s_eth_payload_axis_tready=0, output data/keep/last/user=0, counters=0.
- IDLE:
  - s_eth_hdr_ready=1, payload tready=0.
  - On header handshake, evaluate all channels: match[k] = cfg_ch_en[k] && dest==local[k] && src==remote[k] && type==ethertype[k].
  - Lowest matching k wins and is registered as sel. Any match -> FWD; no match -> DROP.
  - cfg_* is sampled only at header handshake; changes mid-frame do not affect the frame in flight.
- FWD:
  - hdr_ready=0.
  - One-entry output register with full throughput: payload tready = !out_valid || m_axis_net_rx_tready[sel].
  - m_axis_net_rx_tvalid[k] = out_valid && (k==sel); all other channels' tvalid stay 0.
  - Accepted beat with tlast -> IDLE in the same cycle. The register may still hold that last beat; the next header may be accepted while it drains.
  - The sel used by the output register is the one captured with the beat in that register, so back-to-back frames to different channels are not corrupted.
- DROP:
  - payload tready=1; beats are discarded; output register is not loaded.
  - Accepted tlast -> IDLE.
- Latency:
  - Header handshake to first payload acceptance: 1 cycle minimum (FWD/DROP entered on the next edge).
  - Payload in -> out: 1 cycle.
- Back-pressure: in FWD, only the selected channel's tready matters; ready on other channels is ignored.
- Zero-length frames (header with no payload) are not supported. The header parser guarantees at least one payload beat.
- Reset asserted mid-frame:
  - Immediately returns to IDLE and clears out_valid.
  - Remaining beats of the interrupted frame are not accepted until a new header arrives; upstream is reset together.
- Simultaneous match on several channels resolves by lowest index. Two channels with identical config are legal; the higher one never receives frames.

Optional Feature:
- Macro ETH_RX_CHAN_STATS_EN.
- When defined, adds output ports:
  - stat_rx_frames, NUM_CH*CNT_WIDTH: per-channel forwarded-frame counters.
  - stat_drop_frames, CNT_WIDTH: dropped-frame counter.
  - stat_err_frames, CNT_WIDTH: forwarded frames ending with tuser=1.
- Counting rules:
  - Forwarded counters increment on the accepted input tlast in FWD.
  - Drop counter increments on header handshake with no match.
  - All counters saturate at all-ones and reset to 0.
- When undefined: no stat ports, no counter logic.

Decomposition:
- Package eth_rx_chan_pkg:
  - MAC_W=48, ETYPE_W=16.
  - Typedef state_t {IDLE, FWD, DROP}.
  - Function for lowest-index priority encode returning a valid flag and index.
- Sub-module eth_rx_chan_match: purely combinational match vector + priority encoder over NUM_CH; it is unit-testable on its own.
- Top holds FSM, output register, and counters.

Test Plan:
- NUM_CH=4; ch1 = (local 02:00:00:00:00:00, remote 02:00:00:00:00:01, type 0xFFFF), enabled. Send 3-beat frame with that header -> 3 beats on ch1 only, tlast on beat 3, tkeep preserved, other tvalid=0, stat_rx_frames[1]=1.
- Header with type 0x0800 (no match) + 5 beats -> payload tready=1 for all 5, no output tvalid, stat_drop_frames=1, next matching frame forwarded normally.
- ch0 and ch2 configured identically, both enabled -> frames go to ch0. Then clear cfg_ch_en[0] -> frames go to ch2.
- Back-to-back frames to ch1 then ch3, with ch1 tready toggling 1/0 every cycle -> no beat lost or duplicated, no beat of frame 2 appears on ch1, order preserved.
- Assert ap_rst for 1 cycle during beat 2 of a 4-beat frame -> all tvalid=0 asynchronously, FSM IDLE, counters 0, next header accepted.
- Error frame with tuser=1 on tlast to ch0 -> forwarded with m tuser=1 on last beat, stat_err_frames=1.

Source files
------------

// File: rtl/eth_rx_chan_pkg.sv
// Shared types and helpers for the multi-channel RX filter.
// Widths, FSM state type and lowest-index priority encoder.
package eth_rx_chan_pkg;

  localparam int MAC_W   = 48;
  localparam int ETYPE_W = 16;
  localparam int MAX_CH  = 16;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } prio_t;

  function automatic prio_t prio_enc(
    input logic [MAX_CH-1:0] v
  );
    prio_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_rx_chan_match.sv
// Combinational header match over all channels.
// Lowest enabled matching channel wins.
module eth_rx_chan_match
  import eth_rx_chan_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [MAC_W-1:0]          dest_mac,
  input  logic [MAC_W-1:0]          src_mac,
  input  logic [ETYPE_W-1:0]        eth_type,
  input  logic [NUM_CH*MAC_W-1:0]   cfg_local_mac,
  input  logic [NUM_CH*MAC_W-1:0]   cfg_remote_mac,
  input  logic [NUM_CH*ETYPE_W-1:0] cfg_ethertype,
  input  logic [NUM_CH-1:0]         cfg_ch_en,
  output logic                      hit,
  output logic [SEL_W-1:0]          idx
);

  logic [NUM_CH-1:0] match;
  prio_t             enc;

  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      match[k] = cfg_ch_en[k]
        && dest_mac == cfg_local_mac[k*MAC_W +: MAC_W]
        && src_mac  == cfg_remote_mac[k*MAC_W +: MAC_W]
        && eth_type == cfg_ethertype[k*ETYPE_W +: ETYPE_W];
    end
  end

  always_comb begin
    enc = prio_enc(MAX_CH'(match));
    hit = enc.valid;
    idx = SEL_W'(enc.idx);
  end

endmodule

// File: rtl/eth_rx_chan_filter.sv
// Multi-channel RX header filter and payload steering.
// Optional counters enabled by ETH_RX_CHAN_STATS_EN.
module eth_rx_chan_filter
  import eth_rx_chan_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      s_eth_hdr_valid,
  output logic                      s_eth_hdr_ready,
  input  logic [MAC_W-1:0]          s_eth_dest_mac,
  input  logic [MAC_W-1:0]          s_eth_src_mac,
  input  logic [ETYPE_W-1:0]        s_eth_type,
  input  logic [DATA_WIDTH-1:0]     s_eth_payload_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_eth_payload_axis_tkeep,
  input  logic                      s_eth_payload_axis_tvalid,
  output logic                      s_eth_payload_axis_tready,
  input  logic                      s_eth_payload_axis_tlast,
  input  logic                      s_eth_payload_axis_tuser,
  input  logic [NUM_CH*MAC_W-1:0]   cfg_local_mac,
  input  logic [NUM_CH*MAC_W-1:0]   cfg_remote_mac,
  input  logic [NUM_CH*ETYPE_W-1:0] cfg_ethertype,
  input  logic [NUM_CH-1:0]         cfg_ch_en,
  output logic [NUM_CH-1:0]         m_axis_net_rx_tvalid,
  input  logic [NUM_CH-1:0]         m_axis_net_rx_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_net_rx_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_net_rx_tkeep,
  output logic                      m_axis_net_rx_tlast,
  output logic                      m_axis_net_rx_tuser
`ifdef ETH_RX_CHAN_STATS_EN
  ,
  output logic [NUM_CH*CNT_WIDTH-1:0] stat_rx_frames,
  output logic [CNT_WIDTH-1:0]        stat_drop_frames,
  output logic [CNT_WIDTH-1:0]        stat_err_frames
`endif
);

  localparam int KW    = DATA_WIDTH / 8;
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            state;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  out_sel;
  logic [SEL_W-1:0]  hit_idx;
  logic              hit;
  logic              hdr_rdy;
  logic              out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [KW-1:0]     out_keep;
  logic              out_last;
  logic              out_user;
  logic              hdr_fire;
  logic              pay_fire;

  eth_rx_chan_match #(
    .NUM_CH(NUM_CH),
    .SEL_W (SEL_W)
  ) u_match (
    .dest_mac      (s_eth_dest_mac),
    .src_mac       (s_eth_src_mac),
    .eth_type      (s_eth_type),
    .cfg_local_mac (cfg_local_mac),
    .cfg_remote_mac(cfg_remote_mac),
    .cfg_ethertype (cfg_ethertype),
    .cfg_ch_en     (cfg_ch_en),
    .hit           (hit),
    .idx           (hit_idx)
  );

  assign s_eth_hdr_ready = hdr_rdy;
  assign hdr_fire = s_eth_hdr_valid && hdr_rdy;
  assign pay_fire = s_eth_payload_axis_tvalid
                 && s_eth_payload_axis_tready;

  // Drain readiness follows the channel of the beat held in the register.
  always_comb begin
    s_eth_payload_axis_tready = 1'b0;
    unique case (state)
      FWD:  s_eth_payload_axis_tready =
              !out_valid || m_axis_net_rx_tready[out_sel];
      DROP: s_eth_payload_axis_tready = 1'b1;
      default: s_eth_payload_axis_tready = 1'b0;
    endcase
  end

  always_comb begin
    m_axis_net_rx_tvalid = '0;
    if (out_valid) m_axis_net_rx_tvalid[out_sel] = 1'b1;
  end

  assign m_axis_net_rx_tdata = out_data;
  assign m_axis_net_rx_tkeep = out_keep;
  assign m_axis_net_rx_tlast = out_last;
  assign m_axis_net_rx_tuser = out_user;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= IDLE;
      sel       <= '0;
      hdr_rdy   <= 1'b0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else begin
      if (out_valid && m_axis_net_rx_tready[out_sel])
        out_valid <= 1'b0;
      if (state == FWD && pay_fire) begin
        out_valid <= 1'b1;
        out_sel   <= sel;
        out_data  <= s_eth_payload_axis_tdata;
        out_keep  <= s_eth_payload_axis_tkeep;
        out_last  <= s_eth_payload_axis_tlast;
        out_user  <= s_eth_payload_axis_tuser;
      end
      unique case (state)
        IDLE: begin
          hdr_rdy <= 1'b1;
          if (hdr_fire) begin
            sel     <= hit_idx;
            hdr_rdy <= 1'b0;
            state   <= hit ? FWD : DROP;
          end
        end
        FWD, DROP: begin
          if (pay_fire && s_eth_payload_axis_tlast) begin
            state   <= IDLE;
            hdr_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_RX_CHAN_STATS_EN
  logic [CNT_WIDTH-1:0] rx_cnt [NUM_CH];
  logic [CNT_WIDTH-1:0] drop_cnt;
  logic [CNT_WIDTH-1:0] err_cnt;
  logic                 fwd_done;

  assign fwd_done = state == FWD && pay_fire
                 && s_eth_payload_axis_tlast;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
    assign stat_rx_frames[k*CNT_WIDTH +: CNT_WIDTH] = rx_cnt[k];
  end
  assign stat_drop_frames = drop_cnt;
  assign stat_err_frames  = err_cnt;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int k = 0; k < NUM_CH; k++) rx_cnt[k] <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (fwd_done) begin
        if (~&rx_cnt[sel])
          rx_cnt[sel] <= rx_cnt[sel] + CNT_WIDTH'(1);
        if (s_eth_payload_axis_tuser && ~&err_cnt)
          err_cnt <= err_cnt + CNT_WIDTH'(1);
      end
      if (hdr_fire && !hit && ~&drop_cnt)
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_chan_filter.sv
// Randomized bench for eth_rx_chan_filter against a frame-level model.
// Stat checks are active when ETH_RX_CHAN_STATS_EN is defined.
module tb_eth_rx_chan_filter;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int NC = 4;
  localparam int CW = 32;
  localparam int BW = DW + KW + 2;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic            hdr_valid;
  logic            hdr_ready;
  logic [47:0]     dest_mac;
  logic [47:0]     src_mac;
  logic [15:0]     eth_type;
  logic [DW-1:0]   s_tdata;
  logic [KW-1:0]   s_tkeep;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic            s_tuser;
  logic [NC*48-1:0] cfg_local_mac;
  logic [NC*48-1:0] cfg_remote_mac;
  logic [NC*16-1:0] cfg_ethertype;
  logic [NC-1:0]   en;
  logic [NC-1:0]   m_tvalid;
  logic [NC-1:0]   m_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic            m_tuser;
`ifdef ETH_RX_CHAN_STATS_EN
  logic [NC*CW-1:0] stat_rx_frames;
  logic [CW-1:0]    stat_drop_frames;
  logic [CW-1:0]    stat_err_frames;
`endif

  logic [47:0] loc [NC];
  logic [47:0] rem [NC];
  logic [15:0] ety [NC];

  always_comb begin
    cfg_local_mac  = '0;
    cfg_remote_mac = '0;
    cfg_ethertype  = '0;
    for (int k = 0; k < NC; k++) begin
      cfg_local_mac[k*48 +: 48]  = loc[k];
      cfg_remote_mac[k*48 +: 48] = rem[k];
      cfg_ethertype[k*16 +: 16]  = ety[k];
    end
  end

  eth_rx_chan_filter #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NC),
    .CNT_WIDTH (CW)
  ) dut (
    .ap_clk                   (ap_clk),
    .ap_rst                   (ap_rst),
    .s_eth_hdr_valid          (hdr_valid),
    .s_eth_hdr_ready          (hdr_ready),
    .s_eth_dest_mac           (dest_mac),
    .s_eth_src_mac            (src_mac),
    .s_eth_type               (eth_type),
    .s_eth_payload_axis_tdata (s_tdata),
    .s_eth_payload_axis_tkeep (s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid),
    .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast (s_tlast),
    .s_eth_payload_axis_tuser (s_tuser),
    .cfg_local_mac            (cfg_local_mac),
    .cfg_remote_mac           (cfg_remote_mac),
    .cfg_ethertype            (cfg_ethertype),
    .cfg_ch_en                (en),
    .m_axis_net_rx_tvalid     (m_tvalid),
    .m_axis_net_rx_tready     (m_tready),
    .m_axis_net_rx_tdata      (m_tdata),
    .m_axis_net_rx_tkeep      (m_tkeep),
    .m_axis_net_rx_tlast      (m_tlast),
    .m_axis_net_rx_tuser      (m_tuser)
`ifdef ETH_RX_CHAN_STATS_EN
    ,
    .stat_rx_frames           (stat_rx_frames),
    .stat_drop_frames         (stat_drop_frames),
    .stat_err_frames          (stat_err_frames)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: expected beats per channel and frame counters.
  logic [BW-1:0] expq [NC][$];
  int rx_m [NC];
  int drop_m;
  int err_m;
  int rmode;
  logic tgl;

  function automatic int exp_ch(input logic [47:0] d,
                                input logic [47:0] s,
                                input logic [15:0] t);
    for (int k = 0; k < NC; k++)
      if (en[k] && d == loc[k] && s == rem[k] && t == ety[k])
        return k;
    return -1;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int k = 0; k < NC; k++) n += expq[k].size();
    return n;
  endfunction

  initial begin
    m_tready = '1;
    tgl = 1'b0;
    forever begin
      @(posedge ap_clk);
      #1;
      tgl = ~tgl;
      case (rmode)
        1: m_tready = NC'($urandom);
        2: begin
          m_tready = NC'($urandom);
          m_tready[1] = tgl;
        end
        default: m_tready = '1;
      endcase
    end
  end

  always @(negedge ap_clk) begin
    logic [BW-1:0] e;
    if (!ap_rst) begin
      if (m_tvalid != '0)
        chk("onehot", $countones(m_tvalid), 1);
      for (int k = 0; k < NC; k++) begin
        if (m_tvalid[k] && m_tready[k]) begin
          if (expq[k].size() == 0) begin
            chk($sformatf("unexp_ch%0d", k), 1, 0);
          end else begin
            e = expq[k].pop_front();
            chk($sformatf("beat_ch%0d", k),
                {m_tdata, m_tkeep, m_tlast, m_tuser}, e);
          end
        end
      end
    end
  end

  task automatic check_stats();
`ifdef ETH_RX_CHAN_STATS_EN
    for (int k = 0; k < NC; k++)
      chk($sformatf("stat_rx%0d", k),
          stat_rx_frames[k*CW +: CW], rx_m[k]);
    chk("stat_drop", stat_drop_frames, drop_m);
    chk("stat_err", stat_err_frames, err_m);
`endif
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (pending() > 0 && w < 500) begin
      @(posedge ap_clk);
      w++;
    end
    #1;
    chk("drain", pending(), 0);
  endtask

  task automatic send_frame(input logic [47:0] d,
                            input logic [47:0] s,
                            input logic [15:0] t,
                            input int nb,
                            input logic ue,
                            input int rst_beat);
    int ch;
    bit ok;
    logic lst;
    logic usr;
    ch = -1;
    ok = 1'b0;
    @(posedge ap_clk);
    #1;
    dest_mac  = d;
    src_mac   = s;
    eth_type  = t;
    hdr_valid = 1'b1;
    for (int w = 0; w < 100 && !ok; w++) begin
      @(negedge ap_clk);
      ok = hdr_ready;
      if (ok) ch = exp_ch(d, s, t);
      @(posedge ap_clk);
      #1;
    end
    hdr_valid = 1'b0;
    if (!ok) begin
      chk("hdr_timeout", 0, 1);
      return;
    end
    if (ch < 0) drop_m++;
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge ap_clk);
        #1;
      end
      lst = (i == nb - 1);
      usr = lst ? ue : 1'($urandom);
      s_tdata  = {$urandom, $urandom};
      s_tkeep  = KW'($urandom);
      s_tlast  = lst;
      s_tuser  = usr;
      s_tvalid = 1'b1;
      if (i == rst_beat) begin
        #1;
        ap_rst = 1'b1;
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_hdr_rdy", hdr_ready, 0);
        chk("rst_tready", s_tready, 0);
        for (int k = 0; k < NC; k++) begin
          expq[k].delete();
          rx_m[k] = 0;
        end
        drop_m = 0;
        err_m  = 0;
        check_stats();
        @(posedge ap_clk);
        #1;
        ap_rst   = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      ok = 1'b0;
      for (int w = 0; w < 200 && !ok; w++) begin
        @(negedge ap_clk);
        ok = s_tready;
        if (ch < 0 && w == 0) chk("drop_rdy", s_tready, 1);
        if (ok && ch >= 0) begin
          expq[ch].push_back({s_tdata, s_tkeep, lst, usr});
          if (lst) begin
            rx_m[ch]++;
            if (usr) err_m++;
          end
        end
        @(posedge ap_clk);
        #1;
      end
      if (!ok) begin
        chk("beat_timeout", 0, 1);
        s_tvalid = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    int sel;
    hdr_valid = 1'b0;
    dest_mac  = '0;
    src_mac   = '0;
    eth_type  = '0;
    s_tdata   = '0;
    s_tkeep   = '0;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    s_tuser   = 1'b0;
    rmode     = 0;
    drop_m    = 0;
    err_m     = 0;
    for (int k = 0; k < NC; k++) begin
      rx_m[k] = 0;
      loc[k]  = {16'h0a00, 32'($urandom)};
      rem[k]  = {16'h0b00, 32'($urandom)};
      ety[k]  = 16'h8800 + 16'(k);
    end
    loc[1] = 48'h02_00_00_00_00_00;
    rem[1] = 48'h02_00_00_00_00_01;
    ety[1] = 16'hffff;
    en = '1;

    #12;
    chk("rst_tvalid0", m_tvalid, 0);
    chk("rst_hdr_rdy0", hdr_ready, 0);
    chk("rst_tready0", s_tready, 0);
    chk("rst_out0", {m_tdata, m_tkeep, m_tlast, m_tuser}, 0);
    check_stats();
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    send_frame(loc[1], rem[1], ety[1], 3, 1'b0, -1);
    drain();
    check_stats();

    send_frame(loc[1], rem[1], 16'h0800, 5, 1'b0, -1);
    send_frame(loc[1], rem[1], ety[1], 2, 1'b0, -1);
    drain();
    check_stats();

    loc[2] = loc[0];
    rem[2] = rem[0];
    ety[2] = ety[0];
    send_frame(loc[0], rem[0], ety[0], 3, 1'b0, -1);
    en[0] = 1'b0;
    send_frame(loc[0], rem[0], ety[0], 3, 1'b0, -1);
    drain();
    en[0] = 1'b1;
    ety[2] = 16'h88b5;
    check_stats();

    rmode = 2;
    send_frame(loc[1], rem[1], ety[1], 6, 1'b0, -1);
    send_frame(loc[3], rem[3], ety[3], 6, 1'b0, -1);
    drain();
    rmode = 0;

    send_frame(loc[0], rem[0], ety[0], 2, 1'b1, -1);
    drain();
    check_stats();

    for (int f = 0; f < 40; f++) begin
      rmode = $urandom_range(2);
      en = NC'($urandom) | 4'b0010;
      sel = $urandom_range(NC);
      if (sel == NC)
        send_frame({16'hdead, 32'($urandom)}, rem[0],
                   ety[0], $urandom_range(1, 5),
                   1'($urandom), -1);
      else
        send_frame(loc[sel], rem[sel], ety[sel],
                   $urandom_range(1, 6), 1'($urandom), -1);
    end
    rmode = 0;
    en = '1;
    drain();
    check_stats();

    send_frame(loc[1], rem[1], ety[1], 4, 1'b0, 1);
    send_frame(loc[1], rem[1], ety[1], 2, 1'b0, -1);
    drain();
    check_stats();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
